// File: rtl/wr_merge_pkg.sv
// Shared types and widths for the write-channel merge block.
package wr_merge_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       wr_ena;
  } mystruct_s;

endpackage

// File: rtl/wr_merge_fifo.sv
// Synchronous FIFO backing the merge block: occupancy counter plus wrapping
// read/write pointers over a power-of-two storage array.
module wr_merge_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  // Pop is ignored when empty; push into a full FIFO only when a pop frees the slot.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are meaningless until level says otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign level    = level_q;
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);

endmodule

// File: rtl/wr_chan_merge.sv
// Merges NCHAN write channels into one FIFO via a single-grant arbiter
// (round-robin or fixed priority) with a purely combinational grant path.
module wr_chan_merge
  import wr_merge_pkg::*;
#(
  parameter int NCHAN    = 3,
  parameter int DEPTH    = 8,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mystruct_s [NCHAN-1:0]  chan_in,
  output logic [NCHAN-1:0]       chan_rdy,
  input  logic                   enable,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   status
);

  // Handshake: a word moves on a channel (wr_ena/chan_rdy) or on the output
  // (out_vld/out_rdy) only in a cycle where both sides are 1; ready never
  // waits on valid of the same interface beyond what is listed here.

  localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              space_ok;
  logic [LW-1:0]     fifo_level;
  logic              fifo_full, fifo_empty;
  int                arb_idx;

  assign pop      = out_rdy && !fifo_empty;
  assign space_ok = !fifo_full || pop;

  // Walk candidates in priority order; the first requester found takes the grant.
  always_comb begin
    chan_rdy  = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    push_data = '0;
    arb_idx   = 0;
    if (enable && space_ok && !rst) begin
      for (int i = 0; i < NCHAN; i++) begin
        arb_idx = (ARB_MODE == 1) ? i : ((int'(ptr_q) + i) % NCHAN);
        for (int j = 0; j < NCHAN; j++) begin
          if (!gnt_vld && (j == arb_idx) && chan_in[j].wr_ena) begin
            gnt_vld     = 1'b1;
            gnt_idx     = PW'(j);
            push_data   = chan_in[j].data;
            chan_rdy[j] = 1'b1;
          end
        end
      end
    end
  end

  // Pointer advances past the winner; with one channel it is pinned at 0.
  always_comb begin
    ptr_d = ptr_q;
    if ((ARB_MODE == 0) && gnt_vld) begin
      ptr_d = (gnt_idx == PW'(NCHAN - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  wr_merge_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (gnt_vld),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (out_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_vld = !fifo_empty;
  assign level   = fifo_level;
  assign status  = fifo_full;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(chan_rdy));
  a_level_bound:  assert property (@(posedge clk) disable iff (rst) fifo_level <= LW'(DEPTH));

endmodule
